// File: rtl/prog_loader_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader_ctrl_pkg                                                       |
// | Shared state encoding and error codes for the program loader.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package prog_loader_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    LOAD    = 3'd2,
    CHK     = 3'd3,
    RELEASE = 3'd4,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_LEN     = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/prog_loader_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader_ctrl_if                                                        |
// | Byte-stream handshake plus program RAM write port.                         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface prog_loader_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] inst_address;
  logic [DATA_W-1:0] inst_data;
  logic              inst_we;

  modport slave (
    input  in_data, in_valid,
    output in_ready, inst_address, inst_data, inst_we
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, inst_address, inst_data, inst_we
  );
endinterface
`default_nettype wire

// File: rtl/prog_loader_ctrl_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | loader_timeout                                                             |
// | Idle-cycle counter; expired pulses after TIMEOUT enabled cycles w/o clear. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module loader_timeout #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      logic w_unused;
      assign w_unused = clk ^ rst_n ^ clr ^ en;
      assign expired  = 1'b0;
    end else begin : g_counter
      localparam int c_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
      localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT - 1);

      logic [c_W-1:0] r_idle;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_idle <= '0;
        end else if (clr || !en) begin
          r_idle <= '0;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end

      // Fires during the TIMEOUT-th consecutive idle cycle.
      assign expired = en && !clr && (r_idle == c_LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/prog_loader_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader_ctrl                                                           |
// | Frame-based instruction RAM loader holding the core in reset until loaded. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module prog_loader_ctrl
  import prog_loader_ctrl_pkg::*;
#(
  parameter int                ADDR_W      = 7,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE   = DATA_W'(SYNC_BYTE_DEFAULT),
  parameter int                TIMEOUT     = 1023,
  parameter int                RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  prog_loader_ctrl_if.slave bus,
  output logic              core_rst_n,
  output logic              loading,
  output logic [ADDR_W:0]   loaded_len,
  output logic [1:0]        err_code
);

  localparam logic [31:0] c_MAX_LEN = 32'(2 ** ADDR_W);
  localparam int c_REL_W = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
  localparam logic [c_REL_W-1:0] c_REL_LAST =
      (RELEASE_DLY > 0) ? c_REL_W'(RELEASE_DLY - 1) : '0;

  state_t              r_state, w_next;
  logic [1:0]          r_err, w_err;
  logic                r_in_ready, r_we, r_core_rst_n, r_loading;
  logic [ADDR_W-1:0]   r_addr, r_cnt;
  logic [DATA_W-1:0]   r_data, r_csum;
  logic [ADDR_W:0]     r_len, r_loaded_len;
  logic [c_REL_W-1:0]  r_rel_cnt;

  logic w_xfer, w_sync, w_len_ok, w_last, w_in_frame, w_expired, w_wr;

  assign w_xfer     = bus.in_valid && r_in_ready;
  assign w_sync     = (bus.in_data == SYNC_BYTE);
  assign w_len_ok   = (bus.in_data != '0) && (32'(bus.in_data) <= c_MAX_LEN);
  assign w_last     = ({1'b0, r_cnt} == (r_len - 1'b1));
  assign w_in_frame = (r_state == LEN) || (r_state == LOAD) || (r_state == CHK);
  assign w_wr       = (r_state == LOAD) && w_xfer;

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_xfer),
    .en      (w_in_frame),
    .expired (w_expired)
  );

  always_comb begin
    w_next = r_state;
    w_err  = r_err;
    case (r_state)
      IDLE: if (w_xfer && w_sync) w_next = LEN;
      LEN: begin
        if (w_expired) begin
          w_next = ERROR;
          w_err  = ERR_TIMEOUT;
        end else if (w_xfer) begin
          if (w_len_ok) begin
            w_next = LOAD;
          end else begin
            w_next = ERROR;
            w_err  = ERR_LEN;
          end
        end
      end
      LOAD: begin
        if (w_expired) begin
          w_next = ERROR;
          w_err  = ERR_TIMEOUT;
        end else if (w_xfer && w_last) begin
          w_next = CHK;
        end
      end
      CHK: begin
        if (w_expired) begin
          w_next = ERROR;
          w_err  = ERR_TIMEOUT;
        end else if (w_xfer) begin
          if (bus.in_data == r_csum) begin
            w_next = RELEASE;
            w_err  = ERR_NONE;
          end else begin
            w_next = ERROR;
            w_err  = ERR_CSUM;
          end
        end
      end
      RELEASE: if (r_rel_cnt == c_REL_LAST) w_next = RUN;
      RUN:     if (w_xfer && w_sync) w_next = LEN;
      ERROR: begin
        if (w_xfer && w_sync) begin
          w_next = LEN;
          w_err  = ERR_NONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_err        <= ERR_NONE;
      r_in_ready   <= 1'b0;
      r_we         <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_loading    <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_cnt        <= '0;
      r_csum       <= '0;
      r_len        <= '0;
      r_loaded_len <= '0;
      r_rel_cnt    <= '0;
    end else begin
      r_state      <= w_next;
      r_err        <= w_err;
      // Status flags track the state being entered so they line up with it.
      r_in_ready   <= (w_next != RELEASE);
      r_core_rst_n <= (w_next == RUN);
      r_loading    <= (w_next == LEN) || (w_next == LOAD) || (w_next == CHK);
      r_we         <= w_wr;
      if (w_wr) begin
        r_addr <= r_cnt;
        r_data <= bus.in_data;
        r_cnt  <= r_cnt + 1'b1;
        r_csum <= r_csum ^ bus.in_data;
      end
      if ((r_state == LEN) && w_xfer && w_len_ok) begin
        r_len  <= (ADDR_W + 1)'(bus.in_data);
        r_cnt  <= '0;
        r_csum <= '0;
      end
      if ((r_state == CHK) && (w_next == RELEASE)) r_loaded_len <= r_len;
      r_rel_cnt <= (r_state == RELEASE) ? r_rel_cnt + 1'b1 : '0;
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.inst_we      = r_we;
  assign bus.inst_address = r_addr;
  assign bus.inst_data    = r_data;
  assign core_rst_n       = r_core_rst_n;
  assign loading          = r_loading;
  assign loaded_len       = r_loaded_len;
  assign err_code         = r_err;

endmodule
`default_nettype wire
